// File: rtl/logistic_pkg.sv
// Shared widths, defaults and state codes for the logistic bifurcation sweep.
// Optional build macro used by the sweep controller: LOGISTIC_DEDUP_EN.
package logistic_pkg;

    localparam int MU_W       = 18;   // mu, unsigned 2.16
    localparam int X_W        = 17;   // x, unsigned 0.17
    localparam int ROW_W      = 10;
    localparam int COL_W      = 10;

    localparam int COLS_DEF   = 640;
    localparam int ROWS_DEF   = 480;
    localparam int WARMUP_DEF = 256;
    localparam int PLOT_DEF   = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_NEXT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef logic [2:0] state_t;

endpackage

// File: rtl/logistic_row_map.sv
// Maps an x in [0,1) onto a screen row, x=0 at the bottom row and x->1 at row 0.
// Purely combinational so the display path can reuse it.
module logistic_row_map
    import logistic_pkg::*;
#(
    parameter int ROWS = ROWS_DEF
) (
    input  logic [X_W-1:0]   x,
    output logic [ROW_W-1:0] row
);

    localparam logic [ROW_W-1:0] ROWS_C  = ROW_W'(ROWS);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    logic [X_W+ROW_W-1:0] prod;
    logic [ROW_W-1:0]     scaled;

    // full-width product so the shift sees every fractional bit
    assign prod   = {{ROW_W{1'b0}}, x} * {{X_W{1'b0}}, ROWS_C};
    assign scaled = prod[X_W+ROW_W-1:X_W];
    assign row    = ROW_MAX - scaled;

endmodule

// File: rtl/logistic_sweep_ctrl.sv
// Bifurcation sweep sequencer: steps mu per column, drives the logistic iterator and emits pixels.
// Build macro LOGISTIC_DEDUP_EN suppresses repeated rows within a column.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_REQ   | iteration request outstanding (req_q) or one-cycle gap after ack
// ST_WRITE | pixel write presented, held until pix_ready
// ST_NEXT  | column finished, advance mu or finish frame
// ST_DONE  | frame_done pulse
module logistic_sweep_ctrl
    import logistic_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int WARMUP = WARMUP_DEF,
    parameter int PLOT   = PLOT_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [MU_W-1:0]  mu_base,
    input  logic [MU_W-1:0]  mu_step,
    input  logic [X_W-1:0]   x0,
    output logic             busy,
    output logic             frame_done,
    output logic             iter_req,
    output logic [X_W-1:0]   iter_x,
    output logic [MU_W-1:0]  iter_mu,
    input  logic             iter_ack,
    input  logic [X_W-1:0]   iter_y,
    output logic             pix_we,
    output logic [COL_W-1:0] pix_col,
    output logic [ROW_W-1:0] pix_row,
    input  logic             pix_ready
);

    localparam int               CNT_W    = $clog2(WARMUP + PLOT + 1);
    localparam logic [CNT_W-1:0] CNT_WARM = CNT_W'(WARMUP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP + PLOT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    state_t           state;
    logic [COL_W-1:0] col;
    logic [MU_W-1:0]  mu;
    logic [MU_W-1:0]  mu_step_q;
    logic [X_W-1:0]   x;
    logic [X_W-1:0]   x0_q;
    logic [CNT_W-1:0] cnt;
    logic             req_q;
    logic [ROW_W-1:0] row_x;

    logistic_row_map #(.ROWS(ROWS)) u_row_x (
        .x   (x),
        .row (row_x)
    );

`ifdef LOGISTIC_DEDUP_EN
    localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'(WARMUP + PLOT - 1);

    logic [ROW_W-1:0] row_y;
    logic [ROW_W-1:0] last_row;
    logic             last_vld;

    logistic_row_map #(.ROWS(ROWS)) u_row_y (
        .x   (iter_y),
        .row (row_y)
    );
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            col       <= '0;
            mu        <= '0;
            mu_step_q <= '0;
            x         <= '0;
            x0_q      <= '0;
            cnt       <= '0;
            req_q     <= 1'b0;
`ifdef LOGISTIC_DEDUP_EN
            last_row  <= '0;
            last_vld  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mu_step_q <= mu_step;
                        x0_q      <= x0;
                        mu        <= mu_base;
                        x         <= x0;
                        col       <= '0;
                        cnt       <= '0;
                        req_q     <= 1'b1;
                        state     <= ST_REQ;
`ifdef LOGISTIC_DEDUP_EN
                        last_vld  <= 1'b0;
`endif
                    end
                end
                ST_REQ: begin
                    if (req_q) begin
                        if (iter_ack) begin
                            req_q <= 1'b0;
                            x     <= iter_y;
                            cnt   <= cnt + 1'b1;
                            if (cnt >= CNT_WARM) begin
`ifdef LOGISTIC_DEDUP_EN
                                // a repeated row is treated as an already-accepted write
                                if (last_vld && (row_y == last_row)) begin
                                    if (cnt == CNT_PEN) state <= ST_NEXT;
                                end else begin
                                    state <= ST_WRITE;
                                end
`else
                                state <= ST_WRITE;
`endif
                            end
                        end
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (pix_ready) begin
`ifdef LOGISTIC_DEDUP_EN
                        last_row <= row_x;
                        last_vld <= 1'b1;
`endif
                        if (cnt == CNT_LAST) begin
                            state <= ST_NEXT;
                        end else begin
                            req_q <= 1'b1;
                            state <= ST_REQ;
                        end
                    end
                end
                ST_NEXT: begin
`ifdef LOGISTIC_DEDUP_EN
                    last_vld <= 1'b0;
`endif
                    if (col == COL_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        col   <= col + 1'b1;
                        mu    <= mu + mu_step_q;
                        x     <= x0_q;
                        cnt   <= '0;
                        req_q <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state == ST_REQ) || (state == ST_WRITE) || (state == ST_NEXT);
    assign frame_done = (state == ST_DONE);
    assign iter_req   = (state == ST_REQ) && req_q;
    assign iter_x     = x;
    assign iter_mu    = mu;
    assign pix_we     = (state == ST_WRITE);
    assign pix_col    = pix_we ? col : '0;
    assign pix_row    = pix_we ? row_x : '0;

endmodule

// File: doc/logistic_sweep_ctrl.md
Name: logistic_sweep_ctrl

Overview:
- Sequencer for the bifurcation-map datapath: sweeps mu across screen columns and drives an external multi-cycle logistic iterator over a req/ack handshake.
- Per column: discards WARMUP iterations, then turns each of the next PLOT results into a pixel write toward the frame store.
- Sits between the VGA top level (start/status) and the logistic iterator plus frame-buffer write port.

Parameters:
- COLS, 640, columns swept per frame
- ROWS, 480, screen rows; y maps onto 0..ROWS-1
- WARMUP, 256, discarded iterations per column (>=1)
- PLOT, 64, plotted iterations per column (>=1)
- MU_W, 18, mu width, unsigned fixed point 2.16
- X_W, 17, x width, unsigned fraction 0.17

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a frame sweep when idle
- mu_base  in  MU_W  mu for column 0, sampled on accepted start
- mu_step  in  MU_W  mu increment per column, sampled on accepted start
- x0  in  X_W  seed x for every column, sampled on accepted start
- busy  out  1  high from accepted start until frame done
- frame_done  out  1  one-cycle pulse after last column finishes
- iter_req  out  1  request one iteration
- iter_x  out  X_W  x operand
- iter_mu  out  MU_W  mu operand
- iter_ack  in  1  result valid; completes the request
- iter_y  in  X_W  result x(n+1)
- pix_we  out  1  pixel write valid
- pix_col  out  10  pixel column
- pix_row  out  10  pixel row
- pix_ready  in  1  frame store accepts write

Behaviour:
- Reset, synchronous on posedge CLK with RST=1, aborts any sweep mid-operation. Outputs after reset: busy=0, frame_done=0, iter_req=0, pix_we=0. All data outputs and internal counters=0. State=IDLE.
- States:
  - IDLE: start=1 latches mu_base, mu_step and x0; sets col=0, mu=mu_base, x=x0, cnt=0, busy=1; goes to REQ. start is ignored while busy.
  - REQ: iter_req=1 with iter_x=x, iter_mu=mu, both held stable until ack. On the iter_ack cycle: iter_req drops the next cycle, x<=iter_y, cnt++.
    - Warm-up phase (cnt<WARMUP before increment): stay in REQ.
    - Plot phase: go to WRITE.
    - An iter_ack arriving while iter_req=0 is ignored.
  - WRITE: pix_we=1, pix_col=col, pix_row=(ROWS-1)-((x*ROWS)>>X_W). The product is X_W+10 bits with no truncation before the shift, so x=0 gives row ROWS-1 and the largest x gives row 0. Outputs are held until pix_ready=1.
    - On acceptance with cnt==WARMUP+PLOT: go to NEXT.
    - Otherwise: return to REQ.
  - NEXT: if col==COLS-1, go to DONE. Otherwise col++, mu<=mu+mu_step (mod 2^MU_W, wraps silently), x<=x0, cnt=0, then go to REQ.
  - DONE: frame_done=1 for one cycle, busy=0, then IDLE.
- Latency: the first iter_req is asserted the cycle after the accepted start.
- Handshake rules: at most one outstanding request. If pix_ready is already high on entry to WRITE, the write completes in one cycle.
- Back-to-back frames: start arriving in the DONE cycle is ignored; it is accepted only in IDLE.

Optional Feature:
- Macro: LOGISTIC_DEDUP_EN
- Defined: a plot result whose computed row equals the last written row of the same column skips WRITE (pix_we stays 0) and proceeds as if accepted. The last-row register is invalidated in NEXT, so the first plot of each column always writes.
- Undefined: every plot iteration produces exactly one write; a column produces exactly PLOT writes.

Decomposition:
- Shared package logistic_pkg:
  - fixed-point widths MU_W and X_W
  - state enum (IDLE, REQ, WRITE, NEXT, DONE)
  - row-mapping constant for ROWS
- Natural sub-module: logistic_row_map, a combinational mapping of x to row, reused by the display path.

Test Plan:
- Reset mid-sweep: RST=1 during REQ -> next cycle iter_req=0, busy=0; a fresh start restarts at col 0 with mu=mu_base.
- COLS=2, WARMUP=2, PLOT=3, iterator acking in 1 cycle with iter_y=0, pix_ready=1 -> 6 writes, all pix_row=ROWS-1, pix_col 0,0,0,1,1,1; frame_done pulses once; the second column's iter_mu=mu_base+mu_step.
- iter_y=2^16 (x=0.5), ROWS=480 -> pix_row=239; iter_y=2^17-1 -> pix_row=0.
- pix_ready held low 5 cycles in WRITE -> pix_we, pix_col and pix_row stable 5 cycles; no iter_req asserted meanwhile.
- mu_base=2^18-1, mu_step=2 -> column 1 iter_mu=1 (wrap); start pulse while busy -> no effect on the sweep.
- LOGISTIC_DEDUP_EN defined, constant iter_y, PLOT=3 -> one write per column; undefined -> three writes per column.
